// File: rtl/shift_deser_rx.sv
// -----------------------------------------------------------------------------
// shift_deser_rx
// Serial-to-parallel receiver for the far end of a shift-register serial link.
// Samples one qualified bit per clock inside a frame envelope and assembles
// WIDTH-bit words, MSB-first or LSB-first. Completed words are held on a
// parallel output register with a valid/ready handshake; aborted frames pulse
// frame_err and words that arrive while the output is still full set a sticky
// overrun flag.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous active-low reset
//   sin        serial data bit
//   sen        bit qualifier (sin sampled only when sen=1)
//   sframe     frame envelope, high for the whole frame
//   dir        0 = MSB first (enters at LSB), 1 = LSB first (enters at MSB)
//   dout       last completed word
//   dvalid     dout holds an unconsumed word
//   dready     consumer accepts dout when dvalid & dready
//   busy       frame in progress
//   frame_err  one-cycle pulse on frame abort
//   overrun    sticky: a completed word was dropped
//   clr_ovr    clears overrun (a simultaneous new overrun wins)
// -----------------------------------------------------------------------------
module shift_deser_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sen,
  input  logic             sframe,
  input  logic             dir,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);

  // Counter must be able to hold the value WIDTH.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dlat;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_accept;
  logic             w_dir;
  logic             w_last;
  logic [WIDTH-1:0] w_sreg_shift;

  // A bit is taken only inside the envelope and when qualified.
  assign w_accept = sframe & sen;

  // The first bit of a frame uses the live dir; afterwards the latched copy.
  assign w_dir = (r_state == ST_IDLE) ? dir : r_dlat;

  // Shift register contents after shifting in sin; also the completed word
  // on the last bit of a frame.
  assign w_sreg_shift = w_dir ? {sin, r_sreg[WIDTH-1:1]}
                              : {r_sreg[WIDTH-2:0], sin};

  assign w_last = (r_cnt == LAST_CNT);

  // Receive state machine, word delivery and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_dlat      <= 1'b0;
      r_dout      <= '0;
      r_dvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (clr_ovr) begin
        r_overrun <= 1'b0;
      end

      // Consumer handshake; a word completing this edge overrides below.
      if (r_dvalid && dready) begin
        r_dvalid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dlat  <= dir;
            r_sreg  <= w_sreg_shift;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (!sframe) begin
            // Envelope dropped mid-frame: discard the partial word.
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else if (sen) begin
            r_sreg <= w_sreg_shift;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              // Output register is free, or being emptied this same edge.
              if (!r_dvalid || dready) begin
                r_dout   <= w_sreg_shift;
                r_dvalid <= 1'b1;
              end else begin
                // Placed after the clear so a new overrun beats clr_ovr.
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign dvalid    = r_dvalid;
  assign busy      = (r_state == ST_RECV);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_shift_deser_rx.sv
// -----------------------------------------------------------------------------
// tb_shift_deser_rx
// Self-checking bench for shift_deser_rx (WIDTH=4). Expected words are queued
// as frames are sent and compared whenever the DUT presents a new word.
// -----------------------------------------------------------------------------
module tb_shift_deser_rx;

  localparam int unsigned W = 4;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         sin     = 1'b0;
  logic         sen     = 1'b0;
  logic         sframe  = 1'b0;
  logic         dir     = 1'b0;
  logic         dready  = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] sb_q[$];

  logic         prev_dvalid = 1'b0;
  logic         prev_hs     = 1'b0;

  shift_deser_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sen       (sen),
    .sframe    (sframe),
    .dir       (dir),
    .dout      (dout),
    .dvalid    (dvalid),
    .dready    (dready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic f, input logic e, input logic b);
    sframe = f;
    sen    = e;
    sin    = b;
    tick();
  endtask

  // Send one full frame; word is given in natural bit order.
  task automatic send_frame(input logic [W-1:0] word, input logic d,
                            input logic rdy_last, input bit push);
    dir = d;
    for (int i = 0; i < int'(W); i++) begin
      logic b;
      b = d ? word[i] : word[W-1-i];
      if (i == int'(W) - 1) begin
        dready = rdy_last;
        if (push) sb_q.push_back(word);
      end
      drive_bit(1'b1, 1'b1, b);
    end
    sframe = 1'b0;
    sen    = 1'b0;
    dready = 1'b0;
  endtask

  task automatic consume();
    dready = 1'b1;
    tick();
    dready = 1'b0;
  endtask

  // A new word is on dout when dvalid rises, or stays high right after a
  // handshake edge.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (dvalid === 1'b1 && (!prev_dvalid || prev_hs)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word_qsize", 32'(sb_q.size()), 32'(1));
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_word", 32'(dout), 32'(exp_w));
      end
    end
    prev_dvalid = (dvalid === 1'b1);
    prev_hs     = (dvalid === 1'b1) && (dready === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset during traffic, then a normal frame.
    tick();
    tick();
    reset = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1, i[0]);
    chk("rst_dout",      32'(dout),      32'(0));
    chk("rst_dvalid",    32'(dvalid),    32'(0));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_overrun",   32'(overrun),   32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));
    sframe = 1'b0;
    sen    = 1'b0;
    reset  = 1'b1;
    tick();
    send_frame(4'b1001, 1'b0, 1'b0, 1'b1);
    chk("t1_dvalid", 32'(dvalid), 32'(1));
    chk("t1_dout",   32'(dout),   32'h9);
    consume();

    // 2. MSB first, busy tracking, consume.
    dir = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b1);
    chk("t2_busy_e1", 32'(busy), 32'(1));
    drive_bit(1'b1, 1'b1, 1'b0);
    chk("t2_busy_e2", 32'(busy), 32'(1));
    drive_bit(1'b1, 1'b1, 1'b1);
    chk("t2_busy_e3", 32'(busy), 32'(1));
    chk("t2_dvalid_e3", 32'(dvalid), 32'(0));
    sb_q.push_back(4'b1011);
    drive_bit(1'b1, 1'b1, 1'b1);
    sframe = 1'b0;
    sen    = 1'b0;
    chk("t2_busy_e4", 32'(busy),   32'(0));
    chk("t2_dvalid",  32'(dvalid), 32'(1));
    chk("t2_dout",    32'(dout),   32'hB);
    tick();
    chk("t2_dout_hold", 32'(dout), 32'hB);
    consume();
    chk("t2_dvalid_clr", 32'(dvalid), 32'(0));
    chk("t2_dout_keep",  32'(dout),   32'hB);

    // 3. LSB first with stalls, dir toggled mid-frame.
    dir = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    dir = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b1);
    chk("t3_busy_stall", 32'(busy), 32'(1));
    drive_bit(1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0);
    chk("t3_dvalid_e3", 32'(dvalid), 32'(0));
    sb_q.push_back(4'b0001);
    drive_bit(1'b1, 1'b1, 1'b0);
    sframe = 1'b0;
    sen    = 1'b0;
    chk("t3_dvalid", 32'(dvalid), 32'(1));
    chk("t3_dout",   32'(dout),   32'h1);
    consume();

    // 4. Abort mid-frame, then a clean frame.
    dir = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b1);
    chk("t4_busy", 32'(busy), 32'(1));
    drive_bit(1'b0, 1'b0, 1'b0);
    chk("t4_frame_err", 32'(frame_err), 32'(1));
    chk("t4_busy_abort", 32'(busy), 32'(0));
    chk("t4_dvalid", 32'(dvalid), 32'(0));
    tick();
    chk("t4_frame_err_pulse", 32'(frame_err), 32'(0));
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1);
    chk("t4_dout", 32'(dout), 32'h6);
    consume();

    // 5. Back-to-back frames: overrun, overrun vs clear, accept on completion.
    send_frame(4'b1010, 1'b0, 1'b0, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
    chk("t5_dout_kept", 32'(dout),    32'hA);
    chk("t5_overrun",   32'(overrun), 32'(1));
    chk("t5_dvalid",    32'(dvalid),  32'(1));
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t5_ovr_clr", 32'(overrun), 32'(0));
    // New overrun in the same cycle as clr_ovr: overrun must remain set.
    dir = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b1);
    clr_ovr = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b1);
    clr_ovr = 1'b0;
    sframe  = 1'b0;
    sen     = 1'b0;
    chk("t5_ovr_wins", 32'(overrun), 32'(1));
    chk("t5_dout_kept2", 32'(dout), 32'hA);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    consume();
    chk("t5_dvalid_drained", 32'(dvalid), 32'(0));
    send_frame(4'b1010, 1'b0, 1'b0, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1, 1'b1);
    chk("t5_dout_b2b",    32'(dout),    32'h5);
    chk("t5_dvalid_b2b",  32'(dvalid),  32'(1));
    chk("t5_overrun_b2b", 32'(overrun), 32'(0));
    consume();

    // 6. Reset mid-frame discards the partial word silently.
    dir = 1'b0;
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b1);
    reset  = 1'b0;
    sframe = 1'b0;
    sen    = 1'b0;
    tick();
    chk("t6_busy",      32'(busy),      32'(0));
    chk("t6_frame_err", 32'(frame_err), 32'(0));
    reset = 1'b1;
    tick();
    chk("t6_frame_err2", 32'(frame_err), 32'(0));
    send_frame(4'b1100, 1'b0, 1'b0, 1'b1);
    chk("t6_dout",   32'(dout),   32'hC);
    chk("t6_dvalid", 32'(dvalid), 32'(1));
    consume();

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
Serial-to-parallel receiver that sits at the far end of the serial link driven by the universal shift register's lin/rin shift-out path. It samples one qualified serial bit per clock and assembles WIDTH-bit words in either shift direction. Completed words are presented on a parallel output register with a valid/ready handshake. Aborted frames and overruns are flagged.

Parameters:
WIDTH, 4, word width in bits; legal values are 2 and above.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
sin  input  1  serial data bit
sen  input  1  bit qualifier; sin is sampled only when sen=1
sframe  input  1  frame envelope; high for the whole frame
dir  input  1  0 = MSB first (left-shift sense, new bit enters at LSB); 1 = LSB first (right-shift sense, new bit enters at MSB)
dout  output  WIDTH  last completed word
dvalid  output  1  dout holds an unconsumed word
dready  input  1  consumer accepts dout when dvalid & dready
busy  output  1  frame in progress (state RECV)
frame_err  output  1  one-cycle pulse on frame abort
overrun  output  1  sticky; a completed word was dropped
clr_ovr  input  1  clears overrun

Behaviour:
- Reset (reset=0 at a rising edge) has priority over all other events.
  - Outputs: dout=0, dvalid=0, busy=0, frame_err=0, overrun=0.
  - Internal: shift register=0, bit counter=0, state=IDLE.
  - A reset mid-frame discards the partial word with no frame_err.
- Internal state: shift register sreg[WIDTH-1:0], bit counter cnt, latched direction dlat. The counter is wide enough to hold WIDTH.
- Bit accept: "accept" means sframe=1 & sen=1 at a rising edge.
  - dlat=0: sreg <= {sreg[WIDTH-2:0], sin}.
  - dlat=1: sreg <= {sin, sreg[WIDTH-1:1]}.
- State machine, two states:
  - IDLE:
    - On accept: dlat <= dir, shift in the first bit using the incoming dir (not the old dlat), cnt <= 1, go to RECV.
    - Otherwise stay in IDLE.
    - The first accept is always the start of a new frame; sreg is cleared logically by counting, and stale bits shift out.
  - RECV:
    - dir is ignored; dlat holds for the whole frame.
    - sframe=1 & sen=0: stall. No shift, no count change.
    - Accept with cnt<WIDTH-1: shift, cnt++.
    - Accept with cnt=WIDTH-1 (last bit): the assembled word is the sreg value after this shift. It is delivered (see Delivery below), then cnt <= 0 and state goes to IDLE.
    - sframe=0 (any sen): abort. frame_err=1 for exactly one cycle, cnt <= 0, go to IDLE, partial word discarded, dout/dvalid untouched.
- Back-to-back frames: a new frame may start on the cycle immediately after completion, with sframe held high. Maximum throughput is one word per WIDTH clocks.
- busy=1 exactly while state=RECV.
- Delivery, evaluated on the completion edge:
  - dvalid=0: dout <= word, dvalid <= 1.
  - dvalid=1 & dready=1: dout <= new word, dvalid stays 1.
  - dvalid=1 & dready=0: new word dropped, dout keeps the old word, overrun <= 1.
- Latency: the word is visible on dout/dvalid in the cycle after the edge that samples its last bit.
- Handshake:
  - When no word completes, dvalid & dready at an edge gives dvalid <= 0; dout retains its value.
  - dout must stay stable while dvalid=1 and the word is not accepted.
- overrun: sticky. clr_ovr=1 clears it. If clr_ovr and a new overrun occur in the same cycle, the new overrun wins (overrun=1).
- frame_err is 0 in every cycle other than the abort cycle.

Test Plan:
1. Reset: hold reset=0 for 3 clocks mid-traffic -> dout=0000, dvalid=0, busy=0, overrun=0, frame_err=0. Release reset and send a 4-bit frame -> normal reception.
2. MSB-first: dir=0, sframe=1, sen=1, sin=1,0,1,1 on 4 edges -> busy=1 from edge 1 through 3, dout=1011 and dvalid=1 after edge 4. Then dready=1 for one edge -> dvalid=0, dout stays 1011.
3. LSB-first with stalls: dir=1, sin=1,0,0,0 with sen=0 inserted for 2 cycles between bits 2 and 3 -> dout=0001, dvalid rises 1 cycle after the 4th accepted bit. Toggling dir mid-frame has no effect.
4. Abort: dir=0, accept bits 1,1, then drop sframe -> frame_err=1 for one cycle, busy=0, dvalid stays 0. Next frame 0110 -> dout=0110.
5. Overrun and back-to-back: frames 1010 then 0101 on consecutive cycles with dready=0 -> dout=1010, overrun=1. Pulse clr_ovr -> overrun=0. Repeat with dready=1 on the second completion edge -> dout=0101, dvalid=1, overrun=0.
6. Reset mid-frame: 2 bits accepted, then reset=0 for 1 edge -> busy=0, frame_err=0. The next full frame 1100 (dir=0) -> dout=1100.
